// File: rtl/coin_intake.sv
// -----------------------------------------------------------------------------
// coin_intake
//
// Front-end stage of the vending machine. Collects coins into a 4-bit credit,
// latches the product selection, hands one purchase request to the buying
// stage over a valid/ready handshake, waits for its response and finally
// returns the remaining credit as change. Credit is also refunded on cancel
// or after an inactivity timeout.
//
// Parameters:
//   TIMEOUT    idle cycles in CREDIT before an automatic refund
//   TIMER_W    width of the inactivity counter
//   MAX_CREDIT credit ceiling (<= 15)
//
// Ports:
//   clock, reset_n                  clock (rising edge), async active-low reset
//   coin_valid, coin_value          coin insertion strobe and value
//   sel_valid, sel_mode, sel_size   product selection strobe, slot, quantity
//   confirm, cancel                 buy / cancel buttons
//   req_valid, req_ready            purchase request handshake
//   req_cmoney, req_mode, req_csize request payload, stable while req_valid
//   rsp_valid, rsp_ok, rsp_cmoney   one-cycle response from the buying stage
//   change_valid, change_amount     pending change and its value
//   change_ack                      change has been dispensed
//   credit                          current credit, for display
//   coin_reject, redlight, done     one-cycle status pulses
//   busy                            high whenever the stage is not IDLE
// -----------------------------------------------------------------------------
module coin_intake #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TIMER_W    = 8,
    parameter int unsigned MAX_CREDIT = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               coin_valid,
    input  logic [3:0]         coin_value,
    input  logic               sel_valid,
    input  logic [2:0]         sel_mode,
    input  logic [3:0]         sel_size,
    input  logic               confirm,
    input  logic               cancel,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [3:0]         req_cmoney,
    output logic [2:0]         req_mode,
    output logic [3:0]         req_csize,
    input  logic               rsp_valid,
    input  logic               rsp_ok,
    input  logic [3:0]         rsp_cmoney,
    output logic               change_valid,
    output logic [3:0]         change_amount,
    input  logic               change_ack,
    output logic [3:0]         credit,
    output logic               coin_reject,
    output logic               redlight,
    output logic               done,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_REQUEST,
        S_WAIT_RSP,
        S_REFUND
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               sel_held;
    logic [2:0]         sel_mode_q;
    logic [3:0]         sel_size_q;

    // The sum is formed at 5 bits so an overflowing coin is detected instead
    // of silently wrapping the 4-bit credit.
    logic [4:0] coin_sum;
    logic       coin_accept;
    logic       sel_accept;
    logic       timer_expired;

    assign coin_sum      = {1'b0, credit} + {1'b0, coin_value};
    assign coin_accept   = coin_valid && (coin_value != 4'd0) && (coin_sum <= 5'(MAX_CREDIT));
    assign sel_accept    = sel_valid && (sel_size != 4'd0);
    assign timer_expired = (timer == TIMER_W'(TIMEOUT));

    // NOTE: every register here, outputs included, is assigned with <= so all
    // of them update together from the values sampled at the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            timer         <= '0;
            sel_held      <= 1'b0;
            sel_mode_q    <= '0;
            sel_size_q    <= '0;
            credit        <= '0;
            req_valid     <= 1'b0;
            req_cmoney    <= '0;
            req_mode      <= '0;
            req_csize     <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            coin_reject   <= 1'b0;
            redlight      <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; the branches below
            // only ever raise them, so each pulse lasts exactly one cycle.
            coin_reject <= 1'b0;
            redlight    <= 1'b0;
            done        <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (coin_valid && coin_value != 4'd0) begin
                        credit <= coin_value;
                        timer  <= '0;
                        state  <= S_CREDIT;
                        busy   <= 1'b1;
                    end
                end

                // Credit is never zero while in CREDIT (entry needs a non-zero
                // coin and coins only add), so a refund from here always
                // presents change.
                S_CREDIT: begin
                    if (cancel) begin
                        coin_reject   <= coin_valid;
                        change_valid  <= 1'b1;
                        change_amount <= credit;
                        state         <= S_REFUND;
                    end else if (confirm && sel_held) begin
                        coin_reject <= coin_valid;
                        req_valid   <= 1'b1;
                        req_cmoney  <= credit;
                        req_mode    <= sel_mode_q;
                        req_csize   <= sel_size_q;
                        state       <= S_REQUEST;
                    end else if (confirm || timer_expired) begin
                        // A confirm without a selection, or an expiring timer,
                        // consumes the cycle: coins are returned, selections
                        // in the same cycle are not looked at.
                        coin_reject <= coin_valid;
                        redlight    <= confirm;
                        if (timer_expired) begin
                            change_valid  <= 1'b1;
                            change_amount <= credit;
                            state         <= S_REFUND;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end else begin
                        if (coin_accept) begin
                            credit <= coin_sum[3:0];
                        end else if (coin_valid && coin_value != 4'd0) begin
                            coin_reject <= 1'b1;
                        end
                        if (sel_accept) begin
                            sel_held   <= 1'b1;
                            sel_mode_q <= sel_mode;
                            sel_size_q <= sel_size;
                        end else if (sel_valid) begin
                            redlight <= 1'b1;
                        end
                        timer <= (coin_accept || sel_accept) ? '0 : timer + TIMER_W'(1);
                    end
                end

                S_REQUEST: begin
                    coin_reject <= coin_valid;
                    if (req_ready) begin
                        req_valid  <= 1'b0;
                        req_cmoney <= '0;
                        req_mode   <= '0;
                        req_csize  <= '0;
                        state      <= S_WAIT_RSP;
                    end
                end

                S_WAIT_RSP: begin
                    coin_reject <= coin_valid;
                    if (rsp_valid) begin
                        sel_held <= 1'b0;
                        if (rsp_ok) begin
                            credit <= rsp_cmoney;
                            done   <= 1'b1;
                            if (rsp_cmoney != 4'd0) begin
                                change_valid  <= 1'b1;
                                change_amount <= rsp_cmoney;
                                state         <= S_REFUND;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            redlight <= 1'b1;
                            timer    <= '0;
                            state    <= S_CREDIT;
                        end
                    end
                end

                S_REFUND: begin
                    coin_reject <= coin_valid;
                    if (change_ack) begin
                        credit        <= '0;
                        sel_held      <= 1'b0;
                        change_valid  <= 1'b0;
                        change_amount <= '0;
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_intake.sv
// -----------------------------------------------------------------------------
// tb_coin_intake
//
// Scoreboard bench for coin_intake. A driver issues directed and random
// stimulus; for every edge a reference model derives the expected outcome
// and pushes it, time-stamped, into a queue. A monitor on the falling edge
// pops everything due for that edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_coin_intake;

    localparam int TO   = 4;
    localparam int MAXC = 15;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = '0;
    logic       sel_valid = 1'b0;
    logic [2:0] sel_mode = '0;
    logic [3:0] sel_size = '0;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic       req_valid;
    logic       req_ready = 1'b0;
    logic [3:0] req_cmoney;
    logic [2:0] req_mode;
    logic [3:0] req_csize;
    logic       rsp_valid = 1'b0;
    logic       rsp_ok = 1'b0;
    logic [3:0] rsp_cmoney = '0;
    logic       change_valid;
    logic [3:0] change_amount;
    logic       change_ack = 1'b0;
    logic [3:0] credit;
    logic       coin_reject;
    logic       redlight;
    logic       done;
    logic       busy;

    coin_intake #(.TIMEOUT(TO), .TIMER_W(8), .MAX_CREDIT(MAXC)) dut (
        .clock(clock), .reset_n(reset_n),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_mode(sel_mode), .sel_size(sel_size),
        .confirm(confirm), .cancel(cancel),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmoney(req_cmoney), .req_mode(req_mode), .req_csize(req_csize),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_cmoney(rsp_cmoney),
        .change_valid(change_valid), .change_amount(change_amount),
        .change_ack(change_ack), .credit(credit),
        .coin_reject(coin_reject), .redlight(redlight), .done(done), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum {K_STATE, K_REQ, K_CHG, K_DONE, K_RED, K_REJ} kind_t;
    typedef struct {
        int    cyc;
        kind_t kind;
        int    a;
        int    b;
        int    c;
    } ev_t;

    typedef struct {
        bit coin_v; int coin_val;
        bit sel_v;  int mode; int size;
        bit conf;   bit canc;
        bit rdy;    bit rsp_v; bit rsp_ok; int rsp_cm;
        bit ack;
    } stim_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_on = 1'b0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    // ---------------------------------------------------------------- model
    localparam int P_IDLE = 0, P_CREDIT = 1, P_REQUEST = 2, P_WAIT = 3, P_REFUND = 4;
    int m_phase, m_credit, m_mode, m_size, m_cnt;
    bit m_sel;

    task automatic model_reset();
        m_phase = P_IDLE; m_credit = 0; m_mode = 0; m_size = 0; m_cnt = 0; m_sel = 0;
    endtask

    task automatic push(input int stamp, input kind_t k, input int a, input int b, input int c);
        ev_t e;
        e.cyc = stamp; e.kind = k; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic m_refund(input int stamp);
        if (m_credit == 0) begin
            m_phase = P_IDLE;
            m_sel   = 0;
        end else begin
            m_phase = P_REFUND;
            push(stamp, K_CHG, m_credit, 0, 0);
        end
    endtask

    task automatic model_step(input stim_t s);
        int stamp;
        bit rej, red, dn, acc;
        stamp = cyc + 1;
        rej = 0; red = 0; dn = 0; acc = 0;
        case (m_phase)
            P_IDLE: if (s.coin_v && s.coin_val != 0) begin
                m_credit = s.coin_val; m_phase = P_CREDIT; m_cnt = 0;
            end
            P_CREDIT: begin
                if (s.canc) begin
                    rej = s.coin_v; m_refund(stamp);
                end else if (s.conf && m_sel) begin
                    rej = s.coin_v; m_phase = P_REQUEST;
                    push(stamp, K_REQ, m_credit, m_mode, m_size);
                end else if (s.conf || m_cnt == TO) begin
                    rej = s.coin_v; red = s.conf;
                    if (m_cnt == TO) m_refund(stamp);
                    else m_cnt++;
                end else begin
                    if (s.coin_v && s.coin_val != 0) begin
                        if (m_credit + s.coin_val > MAXC) rej = 1;
                        else begin m_credit += s.coin_val; acc = 1; end
                    end
                    if (s.sel_v) begin
                        if (s.size == 0) red = 1;
                        else begin m_sel = 1; m_mode = s.mode; m_size = s.size; acc = 1; end
                    end
                    m_cnt = acc ? 0 : m_cnt + 1;
                end
            end
            P_REQUEST: begin
                rej = s.coin_v;
                if (s.rdy) m_phase = P_WAIT;
            end
            P_WAIT: begin
                rej = s.coin_v;
                if (s.rsp_v) begin
                    m_sel = 0;
                    if (s.rsp_ok) begin
                        m_credit = s.rsp_cm; dn = 1; m_refund(stamp);
                    end else begin
                        red = 1; m_cnt = 0; m_phase = P_CREDIT;
                    end
                end
            end
            default: begin
                rej = s.coin_v;
                if (s.ack) begin m_credit = 0; m_sel = 0; m_phase = P_IDLE; end
            end
        endcase
        push(stamp, K_STATE, m_credit, int'(m_phase != P_IDLE),
             (m_phase == P_REQUEST ? 2 : 0) + (m_phase == P_REFUND ? 1 : 0));
        if (rej) push(stamp, K_REJ, 0, 0, 0);
        if (red) push(stamp, K_RED, 0, 0, 0);
        if (dn)  push(stamp, K_DONE, 0, 0, 0);
    endtask

    // --------------------------------------------------------------- driver
    task automatic drive(input stim_t s);
        coin_valid = s.coin_v; coin_value = s.coin_val[3:0];
        sel_valid  = s.sel_v;  sel_mode = s.mode[2:0]; sel_size = s.size[3:0];
        confirm    = s.conf;   cancel = s.canc;
        req_ready  = s.rdy;
        rsp_valid  = s.rsp_v;  rsp_ok = s.rsp_ok; rsp_cmoney = s.rsp_cm[3:0];
        change_ack = s.ack;
        model_step(s);
        @(posedge clock);
        #1;
    endtask

    task automatic nop();
        stim_t s = '{default: 0};
        drive(s);
    endtask
    task automatic coin(input int v);
        stim_t s = '{default: 0};
        s.coin_v = 1; s.coin_val = v; drive(s);
    endtask
    task automatic sel(input int m, input int z);
        stim_t s = '{default: 0};
        s.sel_v = 1; s.mode = m; s.size = z; drive(s);
    endtask
    task automatic conf();
        stim_t s = '{default: 0};
        s.conf = 1; drive(s);
    endtask
    task automatic canc();
        stim_t s = '{default: 0};
        s.canc = 1; drive(s);
    endtask
    task automatic rdy();
        stim_t s = '{default: 0};
        s.rdy = 1; drive(s);
    endtask
    task automatic rsp(input bit ok, input int cm);
        stim_t s = '{default: 0};
        s.rsp_v = 1; s.rsp_ok = ok; s.rsp_cm = cm; drive(s);
    endtask
    task automatic ack();
        stim_t s = '{default: 0};
        s.ack = 1; drive(s);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear at once.
    task automatic do_reset();
        @(negedge clock);
        #1;
        mon_on  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst req_valid", int'(req_valid), 0);
        check("rst req_cmoney", int'(req_cmoney), 0);
        check("rst req_mode", int'(req_mode), 0);
        check("rst req_csize", int'(req_csize), 0);
        check("rst change_valid", int'(change_valid), 0);
        check("rst change_amount", int'(change_amount), 0);
        check("rst credit", int'(credit), 0);
        check("rst coin_reject", int'(coin_reject), 0);
        check("rst redlight", int'(redlight), 0);
        check("rst done", int'(done), 0);
        check("rst busy", int'(busy), 0);
        coin_valid = 0; sel_valid = 0; confirm = 0; cancel = 0;
        req_ready = 0; rsp_valid = 0; change_ack = 0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        exp_q.delete();
        @(posedge clock);
        #1;
        mon_on = 1'b1;
    endtask

    // -------------------------------------------------------------- monitor
    bit prev_req = 0, prev_chg = 0;
    int held_cm = 0, held_mode = 0, held_size = 0, held_amt = 0;

    always @(negedge clock) begin : monitor
        ev_t e;
        bit  seen_req, seen_chg, seen_done, seen_red, seen_rej;
        if (mon_on) begin
            seen_req = 0; seen_chg = 0; seen_done = 0; seen_red = 0; seen_rej = 0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event %s due at cycle %0d, now %0d", e.kind.name(), e.cyc, cyc);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_STATE: begin
                        check("credit", int'(credit), e.a);
                        check("busy", int'(busy), e.b);
                        check("req_valid", int'(req_valid), e.c >> 1);
                        check("change_valid", int'(change_valid), e.c & 1);
                    end
                    K_REQ: begin
                        seen_req = 1;
                        check("req_rise", int'(req_valid && !prev_req), 1);
                        check("req_cmoney", int'(req_cmoney), e.a);
                        check("req_mode", int'(req_mode), e.b);
                        check("req_csize", int'(req_csize), e.c);
                        held_cm = e.a; held_mode = e.b; held_size = e.c;
                    end
                    K_CHG: begin
                        seen_chg = 1;
                        check("change_rise", int'(change_valid && !prev_chg), 1);
                        check("change_amount", int'(change_amount), e.a);
                        held_amt = e.a;
                    end
                    K_DONE: begin seen_done = 1; check("done", int'(done), 1); end
                    K_RED:  begin seen_red = 1; check("redlight", int'(redlight), 1); end
                    default: begin seen_rej = 1; check("coin_reject", int'(coin_reject), 1); end
                endcase
            end
            if (!seen_done) check("done", int'(done), 0);
            if (!seen_red)  check("redlight", int'(redlight), 0);
            if (!seen_rej)  check("coin_reject", int'(coin_reject), 0);
            if (!seen_req)  check("req_rise", int'(req_valid && !prev_req), 0);
            if (!seen_chg)  check("change_rise", int'(change_valid && !prev_chg), 0);
            if (req_valid && prev_req) begin
                check("req_cmoney hold", int'(req_cmoney), held_cm);
                check("req_mode hold", int'(req_mode), held_mode);
                check("req_csize hold", int'(req_csize), held_size);
            end
            if (change_valid && prev_chg)
                check("change_amount hold", int'(change_amount), held_amt);
            prev_req = req_valid;
            prev_chg = change_valid;
        end else begin
            prev_req = 0;
            prev_chg = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        model_reset();
        do_reset();

        // Full purchase with change.
        coin(5); coin(5); coin(2);
        check("tp1 credit", int'(credit), 12);
        sel(3, 2);
        conf();
        check("tp1 req_valid", int'(req_valid), 1);
        check("tp1 req_cmoney", int'(req_cmoney), 12);
        check("tp1 req_mode", int'(req_mode), 3);
        check("tp1 req_csize", int'(req_csize), 2);
        nop();
        rdy();
        check("tp1 req_valid low", int'(req_valid), 0);
        rsp(1, 4);
        check("tp1 done", int'(done), 1);
        check("tp1 change", int'(change_amount), 4);
        ack();
        check("tp1 idle credit", int'(credit), 0);
        check("tp1 idle busy", int'(busy), 0);

        // Credit ceiling.
        coin(8); coin(5); coin(5);
        check("tp2 reject", int'(coin_reject), 1);
        check("tp2 credit kept", int'(credit), 13);
        coin(2);
        check("tp2 credit 15", int'(credit), 15);
        canc(); ack();

        // Confirm without selection, then cancel.
        coin(3); conf();
        check("tp3 redlight", int'(redlight), 1);
        check("tp3 still credit", int'(busy), 1);
        canc();
        check("tp3 change", int'(change_amount), 3);
        ack();

        // Inactivity timeout: change 5 edges after the last coin.
        coin(7);
        repeat (4) nop();
        check("tp4 not yet", int'(change_valid), 0);
        nop();
        check("tp4 timeout", int'(change_valid), 1);
        check("tp4 amount", int'(change_amount), 7);
        ack();

        // Failed purchase, zero-size selection, coin during WAIT_RSP.
        coin(6); sel(1, 3); sel(5, 0);
        check("tp5 size0 red", int'(redlight), 1);
        conf();
        check("tp5 kept mode", int'(req_mode), 1);
        check("tp5 kept size", int'(req_csize), 3);
        rdy(); coin(2);
        check("tp5 wait reject", int'(coin_reject), 1);
        rsp(0, 0);
        check("tp5 fail red", int'(redlight), 1);
        check("tp5 credit intact", int'(credit), 6);
        conf();
        check("tp5 sel cleared", int'(redlight), 1);
        canc(); ack();

        // Purchase leaving zero credit goes straight to IDLE.
        coin(4); sel(2, 2); conf(); rdy(); rsp(1, 0);
        check("tp6 done", int'(done), 1);
        check("tp6 idle", int'(busy), 0);
        check("tp6 no change", int'(change_valid), 0);

        // Coin together with cancel is rejected.
        begin
            stim_t s = '{default: 0};
            coin(5);
            s.coin_v = 1; s.coin_val = 3; s.canc = 1;
            drive(s);
            check("tp7 reject", int'(coin_reject), 1);
            check("tp7 change", int'(change_amount), 5);
            ack();
        end

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            stim_t s;
            s = '{default: 0};
            if (i % 150 >= 6) begin
                s.coin_v   = ($urandom_range(0, 2) == 0);
                s.coin_val = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 6);
                s.sel_v    = ($urandom_range(0, 3) == 0);
                s.mode     = $urandom_range(0, 7);
                s.size     = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
                s.conf     = ($urandom_range(0, 7) == 0);
                s.canc     = ($urandom_range(0, 24) == 0);
                s.rdy      = ($urandom_range(0, 1) == 0);
                s.rsp_v    = ($urandom_range(0, 2) == 0);
                s.rsp_ok   = ($urandom_range(0, 3) != 0);
                s.rsp_cm   = $urandom_range(0, m_credit);
                s.ack      = ($urandom_range(0, 2) == 0);
            end
            drive(s);
        end
        repeat (2) nop();
        @(negedge clock);
        #1;
        check("scoreboard drained", exp_q.size(), 0);

        // Asynchronous reset while waiting for a response with credit 9.
        do_reset();
        coin(9); sel(2, 1); conf(); rdy();
        check("tp8 credit before reset", int'(credit), 9);
        check("tp8 busy before reset", int'(busy), 1);
        do_reset();
        nop();
        check("tp8 idle after reset", int'(busy), 0);
        coin(4);
        check("tp8 fresh credit", int'(credit), 4);
        nop();
        @(negedge clock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_intake.md
# coin_intake

Front-end stage of the vending machine, directly upstream of the buying stage. Accumulates inserted coins into a 4-bit customer credit, latches the product selection (mode, size), issues one purchase request to the buying stage over a valid/ready handshake, and waits for its response. Afterwards it returns any remaining credit as change. Credit is also refunded on cancel or after an inactivity timeout.

## Interface
- `TIMEOUT`, 255 — idle cycles in CREDIT before an automatic refund (1..2^TIMER_W-1)
- `TIMER_W`, 8 — width of the inactivity counter
- `MAX_CREDIT`, 15 — credit ceiling (≤15)

Ports:
- `clock`  in  1  — single clock, rising edge
- `reset_n`  in  1  — asynchronous, active-low reset
- `coin_valid`  in  1  — one-cycle coin insertion strobe
- `coin_value`  in  4  — value of the inserted coin
- `sel_valid`  in  1  — selection strobe
- `sel_mode`  in  3  — product slot 0..7
- `sel_size`  in  4  — requested quantity
- `confirm`  in  1  — buy button
- `cancel`  in  1  — cancel button
- `req_valid`  out  1  — purchase request to the buying stage
- `req_ready`  in  1  — buying stage accepts the request
- `req_cmoney`  out  4  — credit offered
- `req_mode`  out  3  — latched slot
- `req_csize`  out  4  — latched quantity
- `rsp_valid`  in  1  — one-cycle response from the buying stage
- `rsp_ok`  in  1  — purchase succeeded
- `rsp_cmoney`  in  4  — credit remaining after the purchase
- `change_valid`  out  1  — change pending
- `change_amount`  out  4  — change value
- `change_ack`  in  1  — change dispensed
- `credit`  out  4  — current credit, for display
- `coin_reject`  out  1  — one-cycle pulse: coin returned
- `redlight`  out  1  — one-cycle error pulse
- `done`  out  1  — one-cycle pulse: purchase succeeded
- `busy`  out  1  — high in any state other than IDLE

## Operation
- States: IDLE, CREDIT, REQUEST, WAIT_RSP, REFUND.
- IDLE:
  - A coin with `coin_value` ≠ 0 sets credit to `coin_value` and moves to CREDIT.
  - A coin with value 0 is ignored. `sel_valid`, `confirm` and `cancel` are ignored.
- CREDIT, per-cycle priority is `cancel` > `confirm` > (coin, selection). Coin and selection are both processed in the same cycle.
  - `cancel` → REFUND.
  - `confirm` with a valid selection latched → REQUEST.
  - `confirm` with no selection latched → `redlight` pulse; stay in CREDIT.
  - Coin: if credit + `coin_value` > `MAX_CREDIT`, pulse `coin_reject` and leave credit unchanged. Otherwise add it to credit. The sum is computed at 5 bits; credit never wraps.
  - Selection with `sel_size` = 0 → `redlight` pulse; any previous selection is kept.
  - Any other selection overwrites the latched mode and size.
  - A coin arriving in the same cycle as `cancel` or `confirm` is rejected (`coin_reject`).
  - Inactivity counter: cleared on CREDIT entry and on every accepted coin or selection; increments otherwise. When it equals `TIMEOUT` → REFUND.
- REQUEST:
  - `req_valid` = 1; `req_cmoney`, `req_mode` and `req_csize` are held stable.
  - `req_ready` = 1 → WAIT_RSP. `cancel` is ignored.
- WAIT_RSP:
  - `rsp_valid` with `rsp_ok` = 1: credit ← `rsp_cmoney`, `done` pulses; go to REFUND if the new credit ≠ 0, else IDLE.
  - `rsp_valid` with `rsp_ok` = 0: `redlight` pulses, the selection is cleared, credit is unchanged; return to CREDIT with the counter cleared.
- REFUND:
  - `change_valid` = 1 and `change_amount` = credit.
  - `change_ack` → credit ← 0, selection cleared, go to IDLE.
  - Entering REFUND with credit = 0 goes straight to IDLE without asserting `change_valid`.
- In REQUEST, WAIT_RSP and REFUND, every `coin_valid` produces a `coin_reject` pulse.
- Reset, including mid-transaction: state IDLE, credit 0, selection cleared, counter 0. Every output is 0 (`req_*`, `change_*`, `credit`, `coin_reject`, `redlight`, `done`, `busy`).

## Timing
- All outputs are registered and reflect state after the clock edge.
- `credit` updates one cycle after an accepted coin.
- `req_valid` rises one cycle after `confirm`. It falls in the cycle after the edge that samples `req_valid` && `req_ready`.
- `done`, `redlight` and `coin_reject` are high for exactly one cycle, in the cycle after their cause.
- Inactivity timeout: with no events after the last accepted one, `change_valid` rises `TIMEOUT` + 1 cycles after that event's edge.
- `rsp_valid` outside WAIT_RSP is ignored. `change_ack` outside REFUND is ignored.

## Test plan
- Coins 5, 5, 2, then selection mode=3 size=2, then `confirm` → credit 12; `req_valid` with cmoney=12, mode=3, csize=2; after `req_ready`, response ok with cmoney=4 → `done`, then `change_amount`=4; after `change_ack` → IDLE, credit 0.
- Credit 13, then a coin of 5 → `coin_reject` pulse, credit stays 13; a following coin of 2 → credit 15.
- `confirm` with no selection at credit 3 → `redlight` pulse, state stays CREDIT; then `cancel` → change 3.
- Credit 7, no activity with `TIMEOUT`=4 → `change_valid` with amount 7 exactly 5 cycles after the last coin.
- Response ok=0 → `redlight`, back to CREDIT with credit intact and selection cleared; a coin inserted during WAIT_RSP is rejected.
- Assert `reset_n` = 0 during WAIT_RSP with credit 9 → all outputs 0 immediately (asynchronously), state IDLE after release.
